// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Clock cycles in one complete frame (start + data + parity + stop bits).
    function automatic int unsigned frame_cycles(
        input int unsigned clk_div,
        input int unsigned data_bits,
        input int unsigned parity_bits,
        input int unsigned stop_bits
    );
        return (1 + data_bits + parity_bits + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy flags and a write-overflow pulse.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
        $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next_c;
    logic             wr_ok_c;
    logic             rd_ok_c;

    // A full FIFO drops the write even when a pop frees a slot this cycle.
    assign wr_ok_c   = wr_en && !full;
    assign rd_ok_c   = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (wr_ok_c && !rd_ok_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (!wr_ok_c && rd_ok_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next_c;
            full     <= (count_next_c == CNT_W'(DEPTH));
            empty    <= (count_next_c == '0);
            overflow <= wr_en && full;
        end
    end

    // Storage has no reset; contents are dead once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames are sent back-to-back while data is queued.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2604,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 overflow,
    output logic                 TX
);

    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    if (CLK_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_cfg_err
        $error("uart_tx_fifo: illegal parameter combination");
    end

    tx_state_t            state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_data_c;
    logic                 baud_last_c;
    logic                 baud_pre_last_c;
    logic                 data_last_c;
    logic                 stop_last_c;
    logic                 pop_c;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (pop_c),
        .rd_data_c (fifo_data_c),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    assign baud_last_c     = (baud_cnt == BAUD_W'(CLK_DIV - 1));
    assign baud_pre_last_c = (baud_cnt == BAUD_W'(CLK_DIV - 2));
    assign data_last_c     = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign stop_last_c     = (bit_cnt == BIT_W'(STOP_BITS - 1));

    // Pop when idle, or at the very end of a frame so the next start bit follows with no gap.
    assign pop_c = !empty &&
                   ((state == IDLE) || (state == STOP && baud_last_c && stop_last_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            TX       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state    <= START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        shreg    <= fifo_data_c;
                        busy     <= 1'b1;
                        TX       <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_q    <= (^fifo_data_c) ^ 1'(PARITY_ODD);
`endif
                    end
                end

                START: begin
                    if (baud_last_c) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        TX       <= shreg[0];
                    end
                end

                DATA: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (data_last_c) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            TX      <= par_q;
`else
                            state   <= STOP;
                            TX      <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            TX      <= shreg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last_c) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        TX       <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    // Registered pulse lands on the final cycle of the last stop bit.
                    if (stop_last_c && baud_pre_last_c) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!stop_last_c) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end else if (pop_c) begin
                            state <= START;
                            shreg <= fifo_data_c;
                            TX    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            par_q <= (^fifo_data_c) ^ 1'(PARITY_ODD);
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    busy     <= 1'b0;
                    TX       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: CLK_DIV=16, 8 data bits, 1 stop bit, 4-entry FIFO.
module tb_uart_tx_fifo;

    localparam int unsigned CDIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned NBITS = 10 + PB;
    localparam int unsigned FLEN  = NBITS * CDIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, tx_done, overflow, TX;

    int n_vec = 0;
    int n_bad = 0;

    // frame: bit k is the k-th bit on the line (start, d0..d7, stop); par: even parity of data.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    uart_tx_fifo #(
        .CLK_DIV    (CDIV),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4),
        .PARITY_ODD (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .tx_done  (tx_done),
        .overflow (overflow),
        .TX       (TX)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int k);
        logic [9:0] f;
        f = v.frame;
        if (k <= 8) return f[k];
        if (PB == 1 && k == 9) return v.par;
        return 1'b1;
    endfunction

    // Entered at the sample of frame cycle 0; leaves at the sample one cycle after the frame.
    task automatic run_frame(input vec_t v, input bit idle_after);
        int done_at;
        int done_cnt;
        int k;
        done_at  = -1;
        done_cnt = 0;
        chk($sformatf("busy_start_%02h", v.data), 32'(busy), 1);
        for (int c = 0; c < int'(FLEN); c++) begin
            if (c > 0) @(negedge clk);
            k = c / int'(CDIV);
            if ((c % int'(CDIV)) == 0 || (c % int'(CDIV)) == int'(CDIV / 2) ||
                (c % int'(CDIV)) == int'(CDIV - 1)) begin
                chk($sformatf("tx_%02h_c%0d", v.data, c), 32'(TX), 32'(exp_bit(v, k)));
            end
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
        end
        chk($sformatf("tx_done_count_%02h", v.data), done_cnt, 1);
        chk($sformatf("tx_done_cycle_%02h", v.data), done_at, FLEN - 1);
        @(negedge clk);
        if (idle_after) begin
            chk("busy_after_frame", 32'(busy), 0);
            chk("tx_idle_after_frame", 32'(TX), 1);
        end else begin
            chk("tx_next_start", 32'(TX), 0);
            chk("busy_between_frames", 32'(busy), 1);
        end
    endtask

    task automatic send_one(input vec_t v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = v.data;
        @(negedge clk);
        wr_en = 1'b0;
        chk("tx_high_after_write", 32'(TX), 1);
        chk("empty_after_write", 32'(empty), 0);
        @(negedge clk);
        chk("tx_fall_latency", 32'(TX), 0);
        chk("empty_after_pop", 32'(empty), 1);
        run_frame(v, 1'b1);
    endtask

    initial begin
        int idle_bad;
        int bidx[4];

        vecs[0] = '{8'hA5, 10'h34A, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'h55, 10'h2AA, 1'b0};
        vecs[4] = '{8'h3C, 10'h278, 1'b0};
        vecs[5] = '{8'h41, 10'h282, 1'b0};
        vecs[6] = '{8'h07, 10'h20E, 1'b1};
        vecs[7] = '{8'h80, 10'h300, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(TX), 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_done", 32'(tx_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames from an idle FIFO
        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i]);
        end

        // Back-to-back burst: 00, FF, 55, 3C
        bidx = '{1, 2, 3, 4};
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    wr_en   = 1'b1;
                    wr_data = vecs[bidx[i]].data;
                    @(negedge clk);
                end
                wr_en = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    run_frame(vecs[bidx[i]], i == 3);
                end
            end
        join
        chk("burst_empty_end", 32'(empty), 1);

        // Overflow: six consecutive writes while idle, sixth dropped
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_en   = 1'b1;
                    wr_data = vecs[i].data;
                    @(negedge clk);
                    chk($sformatf("ovf_flag_w%0d", i), 32'(overflow), 32'(i == 5));
                    chk($sformatf("ovf_full_w%0d", i), 32'(full), 32'(i >= 4));
                end
                wr_en = 1'b0;
                @(negedge clk);
                chk("ovf_pulse_width", 32'(overflow), 0);
                chk("ovf_still_full", 32'(full), 1);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    run_frame(vecs[i], i == 4);
                end
            end
        join
        chk("ovf_empty_end", 32'(empty), 1);

        // Reset in the middle of a frame with another byte queued
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h00;
        @(negedge clk);
        wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("midframe_tx_low", 32'(TX), 0);
        chk("midframe_queued", 32'(empty), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(TX), 1);
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (TX !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) idle_bad++;
        end
        chk("post_rst_line_idle", idle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
